serial_pattern_tx: RTL



---
 rtl/serial_pattern_tx.sv | 117 +++++++++++
 1 files changed

// File: rtl/serial_pattern_tx.sv
// Frame serializer: sync pattern, then the data word MSB-first, then a zero gap.
// All outputs are registered from the next-state view, so nothing from i_valid/i_data reaches an output combinationally.
module serial_pattern_tx #(
    parameter int                DATA_W       = 8,
    parameter int                SYNC_W       = 4,
    parameter logic [SYNC_W-1:0] SYNC_PATTERN = 4'b1011,
    parameter int                IDLE_GAP     = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_ready,
    output logic              o_sdata,
    output logic              o_sactive,
    output logic              o_sync,
    output logic              o_done
);

    localparam int MAX_A    = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
    localparam int MAX_N    = (MAX_A > IDLE_GAP) ? MAX_A : IDLE_GAP;
    localparam int CW       = $clog2(MAX_N + 1);
    localparam int GAP_LAST = (IDLE_GAP > 0) ? IDLE_GAP - 1 : 0;

    typedef enum logic [1:0] {IDLE, SYNC, DATA, GAP} state_t;

    state_t            state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [DATA_W-1:0] word_q, word_d;
    logic [SYNC_W-1:0] sync_q, sync_d;
    logic              nxt_ready, nxt_sdata, nxt_sactive, nxt_sync, nxt_done;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            cnt       <= '0;
            word_q    <= '0;
            sync_q    <= '0;
            o_ready   <= 1'b0;
            o_sdata   <= 1'b0;
            o_sactive <= 1'b0;
            o_sync    <= 1'b0;
            o_done    <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            word_q    <= word_d;
            sync_q    <= sync_d;
            o_ready   <= nxt_ready;
            o_sdata   <= nxt_sdata;
            o_sactive <= nxt_sactive;
            o_sync    <= nxt_sync;
            o_done    <= nxt_done;
        end
    end

    // Both shift registers present their current bit at the MSB.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        word_d  = word_q;
        sync_d  = sync_q;
        case (state)
            IDLE: begin
                if (i_valid && o_ready) begin
                    state_n = SYNC;
                    cnt_n   = '0;
                    word_d  = i_data;
                    sync_d  = SYNC_PATTERN;
                end
            end
            SYNC: begin
                if (cnt == CW'(SYNC_W - 1)) begin
                    state_n = DATA;
                    cnt_n   = '0;
                end else begin
                    cnt_n  = cnt + CW'(1);
                    sync_d = sync_q << 1;
                end
            end
            DATA: begin
                if (cnt == CW'(DATA_W - 1)) begin
                    state_n = (IDLE_GAP > 0) ? GAP : IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n  = cnt + CW'(1);
                    word_d = word_q << 1;
                end
            end
            GAP: begin
                if (cnt == CW'(GAP_LAST)) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    always_comb begin
        nxt_ready   = (state_n == IDLE);
        nxt_sactive = (state_n == SYNC) || (state_n == DATA);
        nxt_sync    = (state_n == SYNC);
        nxt_done    = (state_n == DATA) && (cnt_n == CW'(DATA_W - 1));
        nxt_sdata   = 1'b0;
        if (state_n == SYNC)
            nxt_sdata = sync_d[SYNC_W-1];
        else if (state_n == DATA)
            nxt_sdata = word_d[DATA_W-1];
    end

endmodule
